// File: rtl/cpu_sequencer.sv
// Micro-cycle sequencer and instruction register for the 8-bit CPU.
// Closes the loop with the combinational control decoder: feeds it cycle/opcode/eq_zero, acts on its state code.
module cpu_sequencer #(
  parameter int unsigned MAX_CYCLE = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] state,
  input  logic [7:0] bus,
  input  logic       alu_zero,
  input  logic       run,
  input  logic       resume,
  output logic [3:0] cycle,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic       eq_zero,
  output logic       halted,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       error
);

  // Decoder state codes, shared with the control decoder.
  localparam logic [3:0] STATE_NEXT       = 4'h0;
  localparam logic [3:0] STATE_FETCH_PC   = 4'h1;
  localparam logic [3:0] STATE_FETCH_INST = 4'h2;
  localparam logic [3:0] STATE_LOAD_ADDR  = 4'h3;
  localparam logic [3:0] STATE_RAM_A      = 4'h4;
  localparam logic [3:0] STATE_ADD        = 4'h5;
  localparam logic [3:0] STATE_SUB        = 4'h6;
  localparam logic [3:0] STATE_OUT_A      = 4'h7;
  localparam logic [3:0] STATE_HALT       = 4'h8;

  localparam logic [3:0] LAST_CYCLE = 4'(MAX_CYCLE);

  logic [7:0] ir;

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle     <= '0;
      ir        <= '0;
      eq_zero   <= 1'b0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      error     <= 1'b0;
    end else if (halted && resume) begin
      // Resume steps past the HLT cycle so the decoder sees cycle 3 next.
      halted    <= 1'b0;
      cycle     <= cycle + 4'd1;
      out_valid <= 1'b0;
    end else if (halted || !run) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        STATE_NEXT: cycle <= '0;
        STATE_HALT: halted <= 1'b1;
        default: begin
          if (cycle == LAST_CYCLE) begin
            error <= 1'b1;
            cycle <= '0;
          end else begin
            cycle <= cycle + 4'd1;
          end
        end
      endcase

      case (state)
        STATE_FETCH_INST: ir <= bus;
        STATE_ADD, STATE_SUB: eq_zero <= alu_zero;
        STATE_OUT_A: begin
          out_data  <= bus;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a stub decoder is driven by hand, one state code per clock.
module tb_cpu_sequencer;

  localparam logic [3:0] S_NEXT       = 4'h0;
  localparam logic [3:0] S_FETCH_PC   = 4'h1;
  localparam logic [3:0] S_FETCH_INST = 4'h2;
  localparam logic [3:0] S_LOAD_ADDR  = 4'h3;
  localparam logic [3:0] S_RAM_A      = 4'h4;
  localparam logic [3:0] S_ADD        = 4'h5;
  localparam logic [3:0] S_OUT_A      = 4'h7;
  localparam logic [3:0] S_HALT       = 4'h8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] state;
  logic [7:0] bus;
  logic       alu_zero;
  logic       run;
  logic       resume;
  logic [3:0] cycle;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       eq_zero;
  logic       halted;
  logic       out_valid;
  logic [7:0] out_data;
  logic       error;

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.MAX_CYCLE(7)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .state    (state),
    .bus      (bus),
    .alu_zero (alu_zero),
    .run      (run),
    .resume   (resume),
    .cycle    (cycle),
    .opcode   (opcode),
    .operand  (operand),
    .eq_zero  (eq_zero),
    .halted   (halted),
    .out_valid(out_valid),
    .out_data (out_data),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one state code for one clock and check the resulting cycle.
  task automatic step(input logic [3:0] st, input logic [7:0] b, input logic [3:0] exp_cycle,
                      input string tag);
    state = st;
    bus   = b;
    tick();
    check(tag, 32'(cycle), 32'(exp_cycle));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cycle"},   32'(cycle),     0);
    check({tag, "_opcode"},  32'(opcode),    0);
    check({tag, "_operand"}, 32'(operand),   0);
    check({tag, "_eqz"},     32'(eq_zero),   0);
    check({tag, "_halted"},  32'(halted),    0);
    check({tag, "_oval"},    32'(out_valid), 0);
    check({tag, "_odata"},   32'(out_data),  0);
    check({tag, "_error"},   32'(error),     0);
  endtask

  initial begin
    reset_n = 1'b0; state = S_FETCH_PC; bus = 8'h00; alu_zero = 1'b0;
    run = 1'b1; resume = 1'b0;
    #2;
    check_all_zero("reset");
    #5 reset_n = 1'b1;   // released between edges (t=7)
    #1;

    // Unknown state code: advances, captures nothing.
    step(4'hF, 8'hFF, 4'd1, "unk_cycle");
    check("unk_opcode", 32'(opcode), 0);
    step(S_NEXT, 8'h00, 4'd0, "unk_next");

    // Fetch and return to 0.
    step(S_FETCH_PC,   8'h00, 4'd1, "f_c1");
    step(S_FETCH_INST, 8'h1E, 4'd2, "f_c2");
    check("f_opcode",  32'(opcode),  32'h1);
    check("f_operand", 32'(operand), 32'hE);
    step(S_FETCH_PC,   8'h00, 4'd3, "f_c3");
    step(S_LOAD_ADDR,  8'h00, 4'd4, "f_c4");
    step(S_RAM_A,      8'h00, 4'd5, "f_c5");
    check("f_opcode_hold", 32'(opcode), 32'h1);
    step(S_NEXT,       8'h00, 4'd0, "f_c0");

    // ADD with alu_zero=1; resume while running is ignored.
    step(S_FETCH_PC,   8'h00, 4'd1, "add_c1");
    step(S_FETCH_INST, 8'h2D, 4'd2, "add_c2");
    step(S_FETCH_PC,   8'h00, 4'd3, "add_c3");
    resume = 1'b1;
    step(S_LOAD_ADDR,  8'h00, 4'd4, "add_c4_resume_ignored");
    resume = 1'b0;
    check("add_not_halted", 32'(halted), 0);
    alu_zero = 1'b1;
    step(S_ADD,        8'h00, 4'd5, "add_c5");
    check("add_eqz", 32'(eq_zero), 1);
    step(S_NEXT,       8'h00, 4'd0, "add_c0");

    // LDA with alu_zero=0: eq_zero must not move.
    alu_zero = 1'b0;
    step(S_FETCH_PC,   8'h00, 4'd1, "lda_c1");
    check("lda_eqz1", 32'(eq_zero), 1);
    step(S_FETCH_INST, 8'h1F, 4'd2, "lda_c2");
    check("lda_eqz2", 32'(eq_zero), 1);
    check("lda_opcode", 32'(opcode), 32'h1);
    step(S_FETCH_PC,   8'h00, 4'd3, "lda_c3");
    step(S_LOAD_ADDR,  8'h00, 4'd4, "lda_c4");
    step(S_RAM_A,      8'h00, 4'd5, "lda_c5");
    check("lda_eqz5", 32'(eq_zero), 1);
    step(S_NEXT,       8'h00, 4'd0, "lda_c0");
    check("lda_eqz0", 32'(eq_zero), 1);

    // Halt at cycle 2, hold 10 clocks, then resume.
    step(S_FETCH_PC,   8'h00, 4'd1, "hlt_c1");
    step(S_FETCH_INST, 8'hF0, 4'd2, "hlt_c2");
    step(S_HALT,       8'h00, 4'd2, "hlt_enter");
    check("hlt_halted", 32'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hlt_hold_cycle",  32'(cycle),  2);
      check("hlt_hold_halted", 32'(halted), 1);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted", 32'(halted), 0);
    check("resume_cycle",  32'(cycle),  3);
    step(S_NEXT, 8'h00, 4'd0, "resume_next");

    // OUT with a 3-clock run gap during OUT_A.
    step(S_FETCH_PC,   8'h00, 4'd1, "out_c1");
    step(S_FETCH_INST, 8'hE0, 4'd2, "out_c2");
    step(S_FETCH_PC,   8'h00, 4'd3, "out_c3");
    state = S_OUT_A; bus = 8'hA5; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_cycle", 32'(cycle),     3);
      check("gap_oval",  32'(out_valid), 0);
      check("gap_odata", 32'(out_data),  0);
    end
    run = 1'b1;
    tick();
    check("out_cycle", 32'(cycle),     4);
    check("out_oval",  32'(out_valid), 1);
    check("out_odata", 32'(out_data),  32'hA5);
    step(S_NEXT, 8'h00, 4'd0, "out_next");
    check("out_oval_drop",  32'(out_valid), 0);
    check("out_odata_hold", 32'(out_data),  32'hA5);

    // Runaway: LOAD_ADDR forever wraps past cycle 7 and sets error.
    for (int i = 1; i <= 7; i++) begin
      step(S_LOAD_ADDR, 8'h00, 4'(i), "run_cnt");
      check("run_noerr", 32'(error), 0);
    end
    step(S_LOAD_ADDR, 8'h00, 4'd0, "run_wrap");
    check("run_err", 32'(error), 1);
    for (int i = 1; i <= 4; i++) begin
      step(S_LOAD_ADDR, 8'h00, 4'(i), "run_continue");
      check("run_err_sticky", 32'(error), 1);
    end

    // Asynchronous reset at cycle 4, between edges.
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #3 reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
